// File: rtl/rf_writeback_ctrl_if.sv
// Writeback-controller bus: ALU/LSU result handshakes, issue tap, operand
// busy/forward lookup and the register-file write port.
interface rf_writeback_ctrl_if #(
    parameter int XLEN = 32
);
    logic            alu_valid_i;
    logic [4:0]      alu_rd_i;
    logic [XLEN-1:0] alu_wd_i;
    logic            alu_ready_o;
    logic            lsu_valid_i;
    logic [4:0]      lsu_rd_i;
    logic [XLEN-1:0] lsu_wd_i;
    logic            lsu_ready_o;
    logic            issue_valid_i;
    logic [4:0]      issue_rd_i;
    logic [4:0]      rs1_i;
    logic [4:0]      rs2_i;
    logic            rs1_busy_o;
    logic            rs2_busy_o;
    logic            fwd1_sel_o;
    logic            fwd2_sel_o;
    logic [XLEN-1:0] fwd_data_o;
    logic            regwrite_o;
    logic [4:0]      rd_o;
    logic [XLEN-1:0] wd_o;

    // Controller side.
    modport slave (
        input  alu_valid_i, alu_rd_i, alu_wd_i, lsu_valid_i, lsu_rd_i, lsu_wd_i,
               issue_valid_i, issue_rd_i, rs1_i, rs2_i,
        output alu_ready_o, lsu_ready_o, rs1_busy_o, rs2_busy_o, fwd1_sel_o,
               fwd2_sel_o, fwd_data_o, regwrite_o, rd_o, wd_o
    );

    // Execute/LSU/issue side.
    modport master (
        output alu_valid_i, alu_rd_i, alu_wd_i, lsu_valid_i, lsu_rd_i, lsu_wd_i,
               issue_valid_i, issue_rd_i, rs1_i, rs2_i,
        input  alu_ready_o, lsu_ready_o, rs1_busy_o, rs2_busy_o, fwd1_sel_o,
               fwd2_sel_o, fwd_data_o, regwrite_o, rd_o, wd_o
    );
endinterface

// File: rtl/rf_writeback_ctrl.sv
// Arbitrates ALU/LSU writebacks onto the single RF write port, tracks
// per-register pending writes and provides operand busy/forward selects.
module rf_writeback_ctrl #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    rf_writeback_ctrl_if.slave  bus
);
    localparam logic [0:0] LSU_PRI   = 1'b0;
    localparam logic [0:0] ALU_FORCE = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [3:0]      starve_q, starve_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            regwrite_q, regwrite_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wd_q, wd_d;

    logic alu_ready, lsu_ready, alu_xfer, lsu_xfer;
    logic fwd1, fwd2;

    // Readies are forced low during reset so no handshake completes.
    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!reset_i) begin
            if (state_q == ALU_FORCE) begin
                alu_ready = 1'b1;
            end else begin
                lsu_ready = 1'b1;
                alu_ready = ~bus.lsu_valid_i;
            end
        end
    end

    assign alu_xfer = bus.alu_valid_i & alu_ready;
    assign lsu_xfer = bus.lsu_valid_i & lsu_ready;

    // Switch to ALU_FORCE on the edge where the stall count reaches the limit,
    // so the ALU wins the very next cycle.
    always_comb begin
        starve_d = starve_q;
        state_d  = state_q;
        if (alu_xfer)
            starve_d = '0;
        else if (bus.alu_valid_i && starve_q != 4'hF)
            starve_d = starve_q + 4'd1;
        if (state_q == LSU_PRI) begin
            if (starve_d == 4'(STARVE_MAX))
                state_d = ALU_FORCE;
        end else if (alu_xfer) begin
            state_d = LSU_PRI;
        end
    end

    always_comb begin
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        wd_d       = wd_q;
        if (alu_xfer) begin
            regwrite_d = (bus.alu_rd_i != 5'd0);
            rd_d       = bus.alu_rd_i;
            wd_d       = bus.alu_wd_i;
        end else if (lsu_xfer) begin
            regwrite_d = (bus.lsu_rd_i != 5'd0);
            rd_d       = bus.lsu_rd_i;
            wd_d       = bus.lsu_wd_i;
        end
    end

    // Clear on writeback first, then set on issue: set wins on a same-rd collision.
    always_comb begin
        busy_d = busy_q;
        if (alu_xfer) busy_d[bus.alu_rd_i] = 1'b0;
        if (lsu_xfer) busy_d[bus.lsu_rd_i] = 1'b0;
        if (bus.issue_valid_i && bus.issue_rd_i != 5'd0)
            busy_d[bus.issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= LSU_PRI;
            starve_q   <= '0;
            busy_q     <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            busy_q     <= busy_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wd_q       <= wd_d;
        end
    end

    assign fwd1 = regwrite_q & (rd_q == bus.rs1_i) & (bus.rs1_i != 5'd0);
    assign fwd2 = regwrite_q & (rd_q == bus.rs2_i) & (bus.rs2_i != 5'd0);

    assign bus.alu_ready_o = alu_ready;
    assign bus.lsu_ready_o = lsu_ready;
    assign bus.fwd1_sel_o  = fwd1;
    assign bus.fwd2_sel_o  = fwd2;
    assign bus.rs1_busy_o  = busy_q[bus.rs1_i] & ~fwd1;
    assign bus.rs2_busy_o  = busy_q[bus.rs2_i] & ~fwd2;
    assign bus.fwd_data_o  = wd_q;
    assign bus.regwrite_o  = regwrite_q;
    assign bus.rd_o        = rd_q;
    assign bus.wd_o        = wd_q;
endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
Write-side controller for the core's 32x32 register file. Arbitrates result writebacks from the single-cycle ALU path and the multi-cycle load/store unit into the RF's single write port, and drives regwrite/rd/wd as registered outputs. Keeps a per-register busy scoreboard (set at issue, cleared at writeback) and exposes busy/forward information for the RF read operands. Sits between the execute/LSU stages and the register file; the issue stage consumes its busy outputs.

Parameters:
XLEN, 32, data width of write data and forward data
NREG, 32, number of architectural registers (x0 hardwired zero)
STARVE_MAX, 4, consecutive stalled ALU cycles before the ALU is force-granted (1..15)

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  reset
alu_valid_i  in  1  ALU result valid
alu_rd_i  in  5  ALU destination register
alu_wd_i  in  XLEN  ALU result
alu_ready_o  out  1  ALU result accepted this cycle
lsu_valid_i  in  1  LSU result valid
lsu_rd_i  in  5  LSU destination register
lsu_wd_i  in  XLEN  LSU load data
lsu_ready_o  out  1  LSU result accepted this cycle
issue_valid_i  in  1  instruction dispatched this cycle
issue_rd_i  in  5  destination of dispatched instruction
rs1_i, rs2_i  in  5 each  operand register indices
rs1_busy_o, rs2_busy_o  out  1 each  operand has pending write, not forwardable
fwd1_sel_o, fwd2_sel_o  out  1 each  operand must take forward data
fwd_data_o  out  XLEN  forward data (equals wd_o)
regwrite_o  out  1  RF write enable
rd_o  out  5  RF write address
wd_o  out  XLEN  RF write data

Behaviour:
- Reset: clk_i single clock; reset_i asynchronous, active-high. While asserted: regwrite_o=0, rd_o=0, wd_o=0, busy[31:0]=0, starvation counter=0, state=LSU_PRI, alu_ready_o=0, lsu_ready_o=0. Reset mid-operation drops all in-flight handshakes and pending busy bits.
- Handshake: transfer when valid&ready on a rising edge. Sources hold valid, rd and wd stable until accepted. Ready outputs are combinational from state and valids.
- Arbiter FSM, 2 states:
  - LSU_PRI: lsu_ready_o=1; alu_ready_o=~lsu_valid_i.
  - ALU_FORCE: alu_ready_o=1; lsu_ready_o=0.
  - Starvation counter (4 bits) increments each cycle with alu_valid_i & ~alu_ready_o; clears on any ALU transfer.
  - LSU_PRI -> ALU_FORCE when counter==STARVE_MAX at a rising edge. ALU_FORCE -> LSU_PRI on the ALU transfer, which always occurs in the first ALU_FORCE cycle because valid is held.
  - At most one transfer per cycle.
- Write stage: on transfer, next cycle regwrite_o=(rd!=0), rd_o=rd, wd_o=wd. Latency is 1 cycle from transfer to RF write enable. With no transfer, regwrite_o=0 and rd_o/wd_o hold.
  - A write to x0 completes the handshake but never asserts regwrite_o.
- Scoreboard busy[1..31]; busy[0] is constantly 0.
  - Set at edge with issue_valid_i & issue_rd_i!=0.
  - Cleared at the transfer edge for that rd.
  - If issue and clear hit the same rd in the same cycle, set wins.
  - Issue to an already-busy rd leaves it busy. The first writeback clears it; the issue stage is responsible for preventing WAW.
- Operand outputs for N in {1,2}:
  - fwdN_sel_o = regwrite_o & (rd_o==rsN_i) & (rsN_i!=0).
  - rsN_busy_o = busy[rsN_i] & ~fwdN_sel_o.
  - For rsN_i=0, both are 0.
  - Forwarding covers the cycle in which the RF has not yet captured wd_o.

Test Plan:
- Reset: assert reset_i asynchronously mid-cycle with busy[5]=1 and regwrite_o=1 -> immediately regwrite_o=0, rd_o=0, wd_o=0, both readies 0. After release, rs1_i=5 gives rs1_busy_o=0.
- Single ALU write: alu_valid_i=1, rd=3, wd=0xDEADBEEF, lsu idle -> alu_ready_o=1; next cycle regwrite_o=1, rd_o=3, wd_o=0xDEADBEEF; with rs2_i=3, fwd2_sel_o=1 and fwd_data_o=0xDEADBEEF.
- Contention/starvation: LSU and ALU both valid continuously, STARVE_MAX=4 -> LSU accepted for 4 cycles, ALU accepted in cycle 5 with lsu_ready_o=0 in that cycle, then LSU priority resumes and the counter is 0.
- Scoreboard: issue rd=7 at cycle 0 -> rs1_i=7 gives rs1_busy_o=1 from cycle 1. LSU writes rd=7 at cycle 4 -> cycle 5 shows rs1_busy_o=0, fwd1_sel_o=1. Cycle 6 shows both 0.
- Simultaneous set/clear: ALU transfer to rd=9 and issue_rd_i=9 in the same cycle -> busy[9] remains 1 afterwards.
- x0: LSU write rd=0, wd=0x1234 -> lsu_ready_o=1; next cycle regwrite_o=0. Issue rd=0 -> rs1_i=0 gives rs1_busy_o=0 and fwd1_sel_o=0.
